// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: round-robin arbitration of ALU and LSU
// onto the single write port, plus a pending-write scoreboard that stalls issue.
module regfile_wb_ctrl #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_valid,
   input  logic [$clog2(NREG)-1:0] issue_rs1,
   input  logic [$clog2(NREG)-1:0] issue_rs2,
   input  logic [$clog2(NREG)-1:0] issue_rd,
   output logic                    issue_stall,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [$clog2(NREG)-1:0] alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    lsu_valid,
   output logic                    lsu_ready,
   input  logic [$clog2(NREG)-1:0] lsu_rd,
   input  logic [XLEN-1:0]         lsu_data,
   output logic                    write_enable,
   output logic [$clog2(NREG)-1:0] address3,
   output logic [XLEN-1:0]         write_data,
   output logic                    pending_any
);

   localparam int AW = $clog2(NREG);

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e            last_grant;
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_nxt;
   logic              issue_accept;
   logic              handshake;
   logic [AW-1:0]     sel_rd;
   logic [XLEN-1:0]   sel_data;

   // Round-robin: with both requesting, the one not granted last time wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (!rst) begin
         if (alu_valid && (!lsu_valid || last_grant == GRANT_LSU)) begin
            alu_ready = 1'b1;
         end else if (lsu_valid) begin
            lsu_ready = 1'b1;
         end
      end
   end

   assign handshake = alu_ready | lsu_ready;
   assign sel_rd    = lsu_ready ? lsu_rd   : alu_rd;
   assign sel_data  = lsu_ready ? lsu_data : alu_data;

   assign issue_stall  = !rst && issue_valid &&
                         (pending[issue_rs1] || pending[issue_rs2] || pending[issue_rd]);
   assign issue_accept = !rst && issue_valid && !issue_stall;

   // Clear on commit first, then set on issue, so a same-edge collision leaves the bit set.
   always_comb begin
      pending_nxt = pending;
      if (write_enable) begin
         pending_nxt[address3] = 1'b0;
      end
      if (issue_accept) begin
         pending_nxt[issue_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   assign pending_any = |pending;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         pending      <= '0;
         write_enable <= 1'b0;
         address3     <= '0;
         write_data   <= '0;
         last_grant   <= GRANT_LSU;
      end else begin
         pending      <= pending_nxt;
         write_enable <= handshake && (sel_rd != '0);
         if (handshake) begin
            address3   <= sel_rd;
            write_data <= sel_data;
            last_grant <= lsu_ready ? GRANT_LSU : GRANT_ALU;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vector table followed by
// randomized traffic compared against an array-based reference model.
module tb_regfile_wb_ctrl;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_stall;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        write_enable;
   logic [4:0]  address3;
   logic [31:0] write_data;
   logic        pending_any;

   int checks = 0;
   int errors = 0;

   regfile_wb_ctrl #(.NREG(32), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_rd     (issue_rd),
      .issue_stall  (issue_stall),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .write_enable (write_enable),
      .address3     (address3),
      .write_data   (write_data),
      .pending_any  (pending_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   bit          pend [32];
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_last_lsu;
   bit          e_stall, e_ar, e_lr;

   function automatic bit model_any();
      bit r = 1'b0;
      for (int i = 0; i < 32; i++) r |= pend[i];
      return r;
   endfunction

   task automatic model_eval();
      e_stall = !rst && issue_valid && (pend[issue_rs1] || pend[issue_rs2] || pend[issue_rd]);
      e_ar = 1'b0;
      e_lr = 1'b0;
      if (!rst) begin
         if (alu_valid && lsu_valid) begin
            e_ar = m_last_lsu;
            e_lr = !m_last_lsu;
         end else begin
            e_ar = alu_valid;
            e_lr = lsu_valid;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Clock edge: the model consumes the pre-edge inputs and its own state.
   task automatic advance();
      bit          n_pend [32];
      bit          hs;
      logic [4:0]  w_rd;
      logic [31:0] w_data;
      model_eval();
      n_pend = pend;
      hs     = e_ar || e_lr;
      w_rd   = e_lr ? lsu_rd : alu_rd;
      w_data = e_lr ? lsu_data : alu_data;
      if (m_we) n_pend[m_addr] = 1'b0;
      if (issue_valid && !e_stall && !rst) n_pend[issue_rd] = 1'b1;
      n_pend[0] = 1'b0;
      @(posedge clk);
      if (rst) begin
         foreach (pend[i]) pend[i] = 1'b0;
         m_we = 1'b0; m_addr = '0; m_data = '0; m_last_lsu = 1'b1;
      end else begin
         pend = n_pend;
         m_we = hs && (w_rd != 5'd0);
         if (hs) begin
            m_addr = w_rd; m_data = w_data; m_last_lsu = e_lr;
         end
      end
      #1;
   endtask

   task automatic model_check(input string tag);
      model_eval();
      check({tag, " stall"}, issue_stall, e_stall);
      check({tag, " alu_ready"}, alu_ready, e_ar);
      check({tag, " lsu_ready"}, lsu_ready, e_lr);
      check({tag, " write_enable"}, write_enable, m_we);
      check({tag, " address3"}, address3, m_addr);
      check({tag, " write_data"}, write_data, m_data);
      check({tag, " pending_any"}, pending_any, model_any());
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst, iv;
      logic [4:0]  rs1, rs2, rd;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        e_stall, e_ar, e_lr, e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_wd;
      logic        e_any;
   } vec_t;

   function automatic vec_t v(
      logic r, logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
      logic av, logic [4:0] ard, logic [31:0] ad, logic lv, logic [4:0] lrd, logic [31:0] ld,
      logic st, logic ar, logic lr, logic we, logic [4:0] addr, logic [31:0] wd, logic any);
      vec_t t;
      t.rst = r; t.iv = iv; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
      t.av = av; t.ard = ard; t.ad = ad; t.lv = lv; t.lrd = lrd; t.ld = ld;
      t.e_stall = st; t.e_ar = ar; t.e_lr = lr; t.e_we = we;
      t.e_addr = addr; t.e_wd = wd; t.e_any = any;
      return t;
   endfunction

   vec_t vecs [28];

   task automatic drive_idle();
      rst = 1'b0; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
   endtask

   bit          a_hold, l_hold;
   logic [4:0]  a_rd, l_rd;
   logic [31:0] a_dat, l_dat;

   initial begin
      //          rst iv rs1 rs2 rd  av ard adata         lv lrd ldata        st ar lr we adr wdata        any
      vecs[0]  = v(1, 1, 0, 0, 5,   1, 5, 32'hDEADBEEF, 1, 6, 32'h1,       0, 0, 0, 0, 0,  32'h0,       0);
      vecs[1]  = v(0, 0, 0, 0, 0,   1, 5, 32'hDEADBEEF, 0, 0, 32'h0,       0, 1, 0, 0, 0,  32'h0,       0);
      vecs[2]  = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 1, 5,  32'hDEADBEEF, 0);
      vecs[3]  = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 5,  32'hDEADBEEF, 0);
      vecs[4]  = v(0, 1, 1, 2, 7,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 5,  32'hDEADBEEF, 0);
      vecs[5]  = v(0, 1, 7, 0, 0,   1, 7, 32'h77,       0, 0, 32'h0,       1, 1, 0, 0, 5,  32'hDEADBEEF, 1);
      vecs[6]  = v(0, 1, 7, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       1, 0, 0, 1, 7,  32'h77,      1);
      vecs[7]  = v(0, 1, 7, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 7,  32'h77,      0);
      vecs[8]  = v(0, 1, 0, 0, 8,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 7,  32'h77,      0);
      vecs[9]  = v(0, 1, 0, 0, 8,   0, 0, 32'h0,        0, 0, 32'h0,       1, 0, 0, 0, 7,  32'h77,      1);
      vecs[10] = v(0, 1, 0, 0, 0,   0, 0, 32'h0,        1, 8, 32'h88,      0, 0, 1, 0, 7,  32'h77,      1);
      vecs[11] = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 0, 32'h1234,    0, 0, 1, 1, 8,  32'h88,      1);
      vecs[12] = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 0,  32'h1234,    0);
      vecs[13] = v(0, 0, 0, 0, 0,   1, 3, 32'h33,       0, 0, 32'h0,       0, 1, 0, 0, 0,  32'h1234,    0);
      vecs[14] = v(0, 1, 0, 0, 3,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 1, 3,  32'h33,      0);
      vecs[15] = v(0, 1, 0, 3, 0,   0, 0, 32'h0,        0, 0, 32'h0,       1, 0, 0, 0, 3,  32'h33,      1);
      vecs[16] = v(1, 0, 0, 0, 0,   1, 1, 32'hA1,       1, 9, 32'hB9,      0, 0, 0, 0, 3,  32'h33,      1);
      vecs[17] = v(0, 0, 0, 0, 0,   1, 1, 32'hA1,       1, 9, 32'hB9,      0, 1, 0, 0, 0,  32'h0,       0);
      vecs[18] = v(0, 0, 0, 0, 0,   1, 2, 32'hA2,       1, 9, 32'hB9,      0, 0, 1, 1, 1,  32'hA1,      0);
      vecs[19] = v(0, 0, 0, 0, 0,   1, 2, 32'hA2,       1, 10, 32'hBA,     0, 1, 0, 1, 9,  32'hB9,      0);
      vecs[20] = v(0, 0, 0, 0, 0,   1, 3, 32'hA3,       1, 10, 32'hBA,     0, 0, 1, 1, 2,  32'hA2,      0);
      vecs[21] = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 1, 10, 32'hBA,      0);
      vecs[22] = v(0, 1, 0, 0, 8,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0, 10, 32'hBA,      0);
      vecs[23] = v(0, 0, 0, 0, 0,   1, 8, 32'h8888,     0, 0, 32'h0,       0, 1, 0, 0, 10, 32'hBA,      1);
      vecs[24] = v(1, 1, 8, 0, 0,   1, 4, 32'h44,       1, 12, 32'hCC,     0, 0, 0, 1, 8,  32'h8888,    1);
      vecs[25] = v(0, 1, 8, 0, 0,   1, 4, 32'h44,       1, 12, 32'hCC,     0, 1, 0, 0, 0,  32'h0,       0);
      vecs[26] = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 12, 32'hCC,     0, 0, 1, 1, 4,  32'h44,      0);
      vecs[27] = v(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 1, 12, 32'hCC,      0);

      drive_idle();
      rst = 1'b1;
      @(posedge clk); #1;
      advance();
      advance();

      for (int i = 0; i < 28; i++) begin
         rst = vecs[i].rst; issue_valid = vecs[i].iv;
         issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2; issue_rd = vecs[i].rd;
         alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
         lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
         #2;
         check($sformatf("vec%0d stall", i), issue_stall, vecs[i].e_stall);
         check($sformatf("vec%0d alu_ready", i), alu_ready, vecs[i].e_ar);
         check($sformatf("vec%0d lsu_ready", i), lsu_ready, vecs[i].e_lr);
         check($sformatf("vec%0d write_enable", i), write_enable, vecs[i].e_we);
         check($sformatf("vec%0d address3", i), address3, vecs[i].e_addr);
         check($sformatf("vec%0d write_data", i), write_data, vecs[i].e_wd);
         check($sformatf("vec%0d pending_any", i), pending_any, vecs[i].e_any);
         advance();
      end

      // Randomized traffic: requesters hold valid/rd/data until their handshake.
      drive_idle();
      rst = 1'b1;
      advance();
      a_hold = 1'b0;
      l_hold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         issue_valid = $urandom_range(0, 1);
         issue_rs1 = 5'($urandom_range(0, 7));
         issue_rs2 = 5'($urandom_range(0, 7));
         issue_rd  = 5'($urandom_range(0, 7));
         if (!a_hold && $urandom_range(0, 3) != 0) begin
            a_hold = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_dat = $urandom;
         end
         if (!l_hold && $urandom_range(0, 3) != 0) begin
            l_hold = 1'b1; l_rd = 5'($urandom_range(0, 7)); l_dat = $urandom;
         end
         alu_valid = a_hold; alu_rd = a_hold ? a_rd : 5'd0; alu_data = a_hold ? a_dat : 32'd0;
         lsu_valid = l_hold; lsu_rd = l_hold ? l_rd : 5'd0; lsu_data = l_hold ? l_dat : 32'd0;
         #2;
         model_check($sformatf("rnd%0d", c));
         if (e_ar) a_hold = 1'b0;
         if (e_lr) l_hold = 1'b0;
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
